// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle between a requester and the apb_mem_slave completer.
// The master drives the request fields; the slave answers with rdata/ready/err.
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    sel;
  logic                    enable;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] strb;
  logic [2:0]              prot;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    ready;
  logic                    err;

  modport master (
    output sel, enable, write, addr, wdata, strb, prot,
    input  rdata, ready, err
  );

  modport slave (
    input  sel, enable, write, addr, wdata, strb, prot,
    output rdata, ready, err
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB4 completer with a word-organised register memory, byte strobes, wait states,
// a read-only upper region, alignment/range/secure-word error responses and an error counter.
module apb_mem_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int RO_START     = DEPTH,
  parameter int FIXED_WAIT   = 0,
  parameter bit ADDR_WAIT_EN = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  apb_mem_slave_if.slave bus,
  output logic [15:0]    err_cnt
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NBYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIM  = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RO_LIM     = ADDR_WIDTH'(RO_START);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NBYTES-1:0]     strb_q;
  logic                  err_q;
  logic [5:0]            wait_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  load;
  logic                  dec;
  logic                  complete;
  logic                  ready_int;

  logic [ADDR_WIDTH-1:0] setup_word;
  logic                  setup_err;
  logic [5:0]            setup_wait;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  unused_bits;

  // Error classification happens on the live SETUP address so that ACCESS only needs the latched flag.
  assign setup_word = bus.addr >> LSB;
  assign setup_err  = ((bus.addr & ALIGN_MASK) != '0)
                    || (setup_word >= DEPTH_LIM)
                    || (bus.write && (setup_word >= RO_LIM))
                    || (bus.write && bus.prot[1] && (setup_word == '0));
  assign setup_wait = 6'(FIXED_WAIT) + (ADDR_WAIT_EN ? {4'd0, setup_word[1:0]} : 6'd0);

  assign word_q      = addr_q >> LSB;
  assign idx_q       = word_q[IDX_W-1:0];
  assign unused_bits = ^{bus.prot[0], bus.prot[2], word_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    dec      = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sel && !bus.enable) begin
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.sel) begin
          state_d = IDLE;
        end else if (bus.enable) begin
          if (wait_q == 6'd0) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            dec = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state and the latched request, never on the live bus.
  assign ready_int = (state_q == ACCESS) && (wait_q == 6'd0);
  assign bus.ready = ready_int;
  assign bus.err   = ready_int && err_q;
  assign bus.rdata = (ready_int && !write_q && !err_q) ? mem[idx_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      wait_q  <= 6'd0;
      err_cnt <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (load) begin
        addr_q  <= bus.addr;
        write_q <= bus.write;
        wdata_q <= bus.wdata;
        strb_q  <= bus.strb;
        err_q   <= setup_err;
        wait_q  <= setup_wait;
      end else if (dec) begin
        wait_q <= wait_q - 6'd1;
      end

      if (complete) begin
        if (err_q) begin
          if (err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
          end
        end else if (write_q) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (strb_q[b]) begin
              mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: a zero-wait instance (A) and a wait-state instance (B)
// share one driven bus; dsel routes sel to one of them and muxes its responses back.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        dsel;
  logic        sel;
  logic        enable;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic [2:0]  prot;

  logic [15:0] err_cnt_a;
  logic [15:0] err_cnt_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        er;
  int          wt;

  apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
  apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

  assign bus_a.sel    = sel && !dsel;
  assign bus_a.enable = enable;
  assign bus_a.write  = write;
  assign bus_a.addr   = addr;
  assign bus_a.wdata  = wdata;
  assign bus_a.strb   = strb;
  assign bus_a.prot   = prot;

  assign bus_b.sel    = sel && dsel;
  assign bus_b.enable = enable;
  assign bus_b.write  = write;
  assign bus_b.addr   = addr;
  assign bus_b.wdata  = wdata;
  assign bus_b.strb   = strb;
  assign bus_b.prot   = prot;

  wire [31:0] rdata   = dsel ? bus_b.rdata : bus_a.rdata;
  wire        ready   = dsel ? bus_b.ready : bus_a.ready;
  wire        err     = dsel ? bus_b.err   : bus_a.err;
  wire [15:0] err_cnt = dsel ? err_cnt_b   : err_cnt_a;

  apb_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .RO_START(128),
    .FIXED_WAIT(0), .ADDR_WAIT_EN(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .err_cnt(err_cnt_a)
  );

  apb_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .RO_START(128),
    .FIXED_WAIT(2), .ADDR_WAIT_EN(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One complete transfer: SETUP, then ACCESS until ready (bounded), then one more edge to complete.
  task automatic applyStimulus(input logic d, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                               output logic [31:0] rdv, output logic erv, output int waits);
    dsel   = d;
    sel    = 1'b1;
    enable = 1'b0;
    write  = wr;
    addr   = a;
    wdata  = wd;
    strb   = st;
    prot   = pr;
    tick();
    enable = 1'b1;
    waits  = 0;
    while (!ready && waits < 40) begin
      waits++;
      tick();
    end
    rdv = rdata;
    erv = err;
    tick();
    sel    = 1'b0;
    enable = 1'b0;
    write  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the directed sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; dsel = 1'b0; sel = 1'b0; enable = 1'b0; write = 1'b0;
    addr = '0; wdata = '0; strb = '0; prot = '0;
    repeat (3) tick();
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Zero-wait write then read on A
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, wt);
    checkOutput("wr10_waits", 32'(wt), 32'd0);
    checkOutput("wr10_rdata_zero", rd, 32'd0);
    checkOutput("wr10_err", {31'd0, er}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("rd10_waits", 32'(wt), 32'd0);
    checkOutput("rd10_data", rd, 32'hDEADBEEF);
    checkOutput("rd10_err", {31'd0, er}, 32'd0);

    // Partial strobes
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 3'b000, rd, er, wt);
    applyStimulus(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, rd, er, wt);
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("rd20_merged", rd, 32'h11BB33DD);

    // All-zero strobe write is a legal no-op
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h12345678, 4'h0, 3'b000, rd, er, wt);
    checkOutput("strb0_err", {31'd0, er}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("strb0_unchanged", rd, 32'hDEADBEEF);

    // Error responses on A: misaligned, out of range, read-only, non-secure to word 0
    applyStimulus(1'b0, 1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, wt);
    checkOutput("mis_err", {31'd0, er}, 32'd1);
    checkOutput("mis_rdata", rd, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("oor_err", {31'd0, er}, 32'd1);
    checkOutput("oor_rdata", rd, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h320, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, wt);
    checkOutput("ro_err", {31'd0, er}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, 3'b010, rd, er, wt);
    checkOutput("nonsec_err", {31'd0, er}, 32'd1);
    checkOutput("err_cnt_4", {16'd0, err_cnt}, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b010, rd, er, wt);
    checkOutput("word0_unchanged", rd, 32'd0);
    checkOutput("word0_read_err", {31'd0, er}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h320, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("ro_unchanged", rd, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("mis_target_unchanged", rd, 32'd0);

    // Secure write to word 0 and the RO boundary (127 writable, 128 not)
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h00000055, 4'hF, 3'b000, rd, er, wt);
    checkOutput("sec_wr_err", {31'd0, er}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("sec_wr_data", rd, 32'h00000055);
    applyStimulus(1'b0, 1'b1, 32'h1FC, 32'hA5A5A5A5, 4'hF, 3'b000, rd, er, wt);
    checkOutput("idx127_err", {31'd0, er}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h200, 32'hA5A5A5A5, 4'hF, 3'b000, rd, er, wt);
    checkOutput("idx128_err", {31'd0, er}, 32'd1);
    checkOutput("err_cnt_5", {16'd0, err_cnt}, 32'd5);
    applyStimulus(1'b0, 1'b0, 32'h1FC, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("idx127_data", rd, 32'hA5A5A5A5);

    // Wait states on B: 2 fixed + index[1:0]
    applyStimulus(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("b_rd0c_waits", 32'(wt), 32'd5);
    checkOutput("b_rd0c_data", rd, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, wt);
    checkOutput("b_wr0c_waits", 32'(wt), 32'd5);
    applyStimulus(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("b_rd0c_new", rd, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 32'h401, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("b_mis_waits", 32'(wt), 32'd2);
    checkOutput("b_mis_err", {31'd0, er}, 32'd1);
    checkOutput("b_err_cnt_1", {16'd0, err_cnt}, 32'd1);

    // Abort on B: 3-wait write to 0x04, sel dropped after one ACCESS cycle
    dsel = 1'b1; sel = 1'b1; enable = 1'b0; write = 1'b1;
    addr = 32'h04; wdata = 32'h0BADC0DE; strb = 4'hF; prot = 3'b000;
    tick();
    enable = 1'b1;
    checkOutput("abort_ready_a1", {31'd0, ready}, 32'd0);
    tick();
    sel = 1'b0; enable = 1'b0; write = 1'b0;
    checkOutput("abort_ready_a2", {31'd0, ready}, 32'd0);
    tick();
    checkOutput("abort_ready_idle", {31'd0, ready}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("abort_rd_waits", 32'(wt), 32'd3);
    checkOutput("abort_rd_data", rd, 32'd0);
    checkOutput("abort_rd_err", {31'd0, er}, 32'd0);
    checkOutput("abort_err_cnt", {16'd0, err_cnt}, 32'd1);

    // Reset during a wait-state write on B (index 2, four waits)
    dsel = 1'b1; sel = 1'b1; enable = 1'b0; write = 1'b1;
    addr = 32'h08; wdata = 32'h12345678; strb = 4'hF; prot = 3'b000;
    tick();
    enable = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_ready", {31'd0, ready}, 32'd0);
    checkOutput("rst_mid_err", {31'd0, err}, 32'd0);
    checkOutput("rst_mid_rdata", rdata, 32'd0);
    checkOutput("rst_mid_err_cnt", {16'd0, err_cnt}, 32'd0);
    rst = 1'b0; sel = 1'b0; enable = 1'b0; write = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("rst_mid_word", rd, 32'd0);
    checkOutput("rst_mid_rd_waits", 32'(wt), 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, wt);
    checkOutput("rst_cleared_a10", rd, 32'd0);
    checkOutput("rst_cleared_a_cnt", {16'd0, err_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
